// File: rtl/vadd_pkg.sv
// Shared definitions for the vector-add sequencer: FSM state encoding and
// the per-element byte stride.
package vadd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_DATA  = 3'd2,
        WR_REQ   = 3'd3,
        WR_DATA  = 3'd4,
        DONE     = 3'd5,
        WAIT_CLR = 3'd6
    } vadd_state_e;

    localparam int unsigned STRIDE_BYTES = 8;

endpackage

// File: rtl/vadd_sequencer_if.sv
// Memory-side handshake bundle: request channel, write-data channel and
// read-data channel. The sequencer is the master, the memory the slave.
interface vadd_sequencer_if #(
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64
);
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_opcode;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic                     mem_wr_valid;
    logic                     mem_wr_ready;
    logic [MEM_DATA_BITS-1:0] mem_wr_bits;
    logic                     mem_rd_valid;
    logic                     mem_rd_ready;
    logic [MEM_DATA_BITS-1:0] mem_rd_bits;

    modport master (
        output mem_req_valid, mem_req_opcode, mem_req_addr,
        output mem_wr_valid, mem_wr_bits, mem_rd_ready,
        input  mem_req_ready, mem_wr_ready, mem_rd_valid, mem_rd_bits
    );

    modport slave (
        input  mem_req_valid, mem_req_opcode, mem_req_addr,
        input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
        output mem_req_ready, mem_wr_ready, mem_rd_valid, mem_rd_bits
    );
endinterface

// File: rtl/vadd_cycle_counter.sv
// Saturating up-counter for busy cycles; clear wins over enable and the
// count sticks at all-ones instead of wrapping.
module vadd_cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vadd_sequencer.sv
// Streams length elements from inp_baddr, adds a constant, writes them to
// out_baddr, then reports the busy-cycle count with a one-cycle finish pulse.
//
// state    | meaning
// IDLE     | waiting for launch; config snapshot taken on launch
// RD_REQ   | read request for element i outstanding
// RD_DATA  | waiting for read data, result registered on arrival
// WR_REQ   | write request for element i outstanding
// WR_DATA  | write data offered; advances i on acceptance
// DONE     | single-cycle finish / counter report
// WAIT_CLR | holds until launch drops so a stale launch cannot restart
module vadd_sequencer
    import vadd_pkg::*;
#(
    parameter int MEM_ADDR_BITS  = 64,
    parameter int MEM_DATA_BITS  = 64,
    parameter int HOST_DATA_BITS = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      launch,
    output logic                      finish,
    output logic                      event_counter_valid,
    output logic [HOST_DATA_BITS-1:0] event_counter_value,
    input  logic [HOST_DATA_BITS-1:0] constant,
    input  logic [HOST_DATA_BITS-1:0] length,
    input  logic [MEM_ADDR_BITS-1:0]  inp_baddr,
    input  logic [MEM_ADDR_BITS-1:0]  out_baddr,
    vadd_sequencer_if.master          mem
);

    vadd_state_e               state_q, state_d;
    logic [HOST_DATA_BITS-1:0] i_q, i_d;
    logic [HOST_DATA_BITS-1:0] const_q, const_d;
    logic [HOST_DATA_BITS-1:0] len_q, len_d;
    logic [MEM_ADDR_BITS-1:0]  inp_q, inp_d;
    logic [MEM_ADDR_BITS-1:0]  out_q, out_d;
    logic [MEM_DATA_BITS-1:0]  result_q, result_d;

    logic                      cnt_clear;
    logic                      cnt_enable;
    logic [HOST_DATA_BITS-1:0] cnt_value;
    logic [HOST_DATA_BITS-1:0] cnt_report;
    logic [MEM_ADDR_BITS-1:0]  offset;
    logic [HOST_DATA_BITS:0]   i_inc;
    logic                      last_elem;

    assign offset    = MEM_ADDR_BITS'(i_q) * MEM_ADDR_BITS'(STRIDE_BYTES);
    // One extra bit so length = all-ones terminates instead of wrapping.
    assign i_inc     = {1'b0, i_q} + (HOST_DATA_BITS+1)'(1);
    assign last_elem = (i_inc == {1'b0, len_q});

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        const_d   = const_q;
        len_d     = len_q;
        inp_d     = inp_q;
        out_d     = out_q;
        result_d  = result_q;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    const_d   = constant;
                    len_d     = length;
                    inp_d     = inp_baddr;
                    out_d     = out_baddr;
                    i_d       = '0;
                    cnt_clear = 1'b1;
                    state_d   = (length == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (mem.mem_req_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (mem.mem_rd_valid) begin
                    result_d = mem.mem_rd_bits + MEM_DATA_BITS'(const_q);
                    state_d  = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem.mem_req_ready) state_d = WR_DATA;
            end
            WR_DATA: begin
                if (mem.mem_wr_ready) begin
                    i_d     = i_inc[HOST_DATA_BITS-1:0];
                    state_d = last_elem ? DONE : RD_REQ;
                end
            end
            DONE:     state_d = WAIT_CLR;
            WAIT_CLR: begin
                if (!launch) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            const_q  <= '0;
            len_q    <= '0;
            inp_q    <= '0;
            out_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            const_q  <= const_d;
            len_q    <= len_d;
            inp_q    <= inp_d;
            out_q    <= out_d;
            result_q <= result_d;
        end
    end

    assign cnt_enable = (state_q != IDLE) && (state_q != WAIT_CLR);

    vadd_cycle_counter #(
        .WIDTH (HOST_DATA_BITS)
    ) u_cycle_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (cnt_value)
    );

    // The report includes the DONE cycle itself, which the counter has not yet absorbed.
    assign cnt_report = (cnt_value == '1) ? cnt_value : cnt_value + HOST_DATA_BITS'(1);

    assign mem.mem_req_valid    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem.mem_req_opcode   = (state_q == WR_REQ);
    assign mem.mem_req_addr     = (state_q == RD_REQ) ? inp_q + offset :
                                  (state_q == WR_REQ) ? out_q + offset : '0;
    assign mem.mem_wr_valid     = (state_q == WR_DATA);
    assign mem.mem_wr_bits      = (state_q == WR_DATA) ? result_q : '0;
    assign mem.mem_rd_ready     = (state_q == RD_DATA);

    assign finish               = (state_q == DONE);
    assign event_counter_valid  = (state_q == DONE);
    assign event_counter_value  = (state_q == DONE) ? cnt_report : '0;

endmodule

// File: tb/tb_vadd_sequencer.sv
// Self-checking bench for vadd_sequencer: a randomized-latency memory model
// plus per-scenario tasks compared against an arithmetic reference.
module tb_vadd_sequencer;

    localparam int A = 64;
    localparam int D = 64;
    localparam int H = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         launch = 1'b0;
    logic         finish;
    logic         ev_valid;
    logic [H-1:0] ev_value;
    logic [H-1:0] constant = '0;
    logic [H-1:0] length = '0;
    logic [A-1:0] inp_baddr = '0;
    logic [A-1:0] out_baddr = '0;

    vadd_sequencer_if #(.MEM_ADDR_BITS(A), .MEM_DATA_BITS(D)) mem_if ();

    vadd_sequencer #(
        .MEM_ADDR_BITS  (A),
        .MEM_DATA_BITS  (D),
        .HOST_DATA_BITS (H)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .launch              (launch),
        .finish              (finish),
        .event_counter_valid (ev_valid),
        .event_counter_value (ev_value),
        .constant            (constant),
        .length              (length),
        .inp_baddr           (inp_baddr),
        .out_baddr           (out_baddr),
        .mem                 (mem_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    logic [63:0] mem_arr [logic [63:0]];
    logic [63:0] rd_addr_q [$];
    logic [63:0] wr_addr_q [$];
    wr_t         wr_log [$];
    int          n_rd_req = 0;
    int          n_wr_req = 0;
    int          max_delay = 0;
    int          forced_stall = 0;
    bit          block_wr_req = 0;
    int          req_wait = 0, rd_wait = 0, wr_wait = 0;
    bit          req_armed = 0, rd_armed = 0, wr_armed = 0;

    initial begin
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rd_valid  = 1'b0;
        mem_if.mem_rd_bits   = '0;
        mem_if.mem_wr_ready  = 1'b0;
        forever begin
            @(negedge clock);
            mem_if.mem_req_ready = 1'b0;
            mem_if.mem_rd_valid  = 1'b0;
            mem_if.mem_rd_bits   = '0;
            mem_if.mem_wr_ready  = 1'b0;
            if (!reset) begin
                rd_addr_q.delete();
                wr_addr_q.delete();
                req_armed = 0;
                rd_armed  = 0;
                wr_armed  = 0;
            end else begin
                if (mem_if.mem_req_valid && !(block_wr_req && mem_if.mem_req_opcode)) begin
                    if (!req_armed) begin
                        req_armed = 1;
                        if (forced_stall > 0) begin
                            req_wait     = forced_stall;
                            forced_stall = 0;
                        end else begin
                            req_wait = $urandom_range(max_delay);
                        end
                    end
                    if (req_wait == 0) begin
                        mem_if.mem_req_ready = 1'b1;
                        req_armed = 0;
                        if (mem_if.mem_req_opcode) begin
                            wr_addr_q.push_back(mem_if.mem_req_addr);
                            n_wr_req++;
                        end else begin
                            rd_addr_q.push_back(mem_if.mem_req_addr);
                            n_rd_req++;
                        end
                    end else begin
                        req_wait--;
                    end
                end
                if (mem_if.mem_rd_ready && rd_addr_q.size() > 0) begin
                    if (!rd_armed) begin
                        rd_armed = 1;
                        rd_wait  = $urandom_range(max_delay);
                    end
                    if (rd_wait == 0) begin
                        logic [63:0] a;
                        a = rd_addr_q.pop_front();
                        mem_if.mem_rd_valid = 1'b1;
                        mem_if.mem_rd_bits  = mem_arr.exists(a) ? mem_arr[a] : 64'h0;
                        rd_armed = 0;
                    end else begin
                        rd_wait--;
                    end
                end
                if (mem_if.mem_wr_valid && wr_addr_q.size() > 0) begin
                    if (!wr_armed) begin
                        wr_armed = 1;
                        wr_wait  = $urandom_range(max_delay);
                    end
                    if (wr_wait == 0) begin
                        wr_t w;
                        w.addr = wr_addr_q.pop_front();
                        w.data = mem_if.mem_wr_bits;
                        wr_log.push_back(w);
                        mem_if.mem_wr_ready = 1'b1;
                        wr_armed = 0;
                    end else begin
                        wr_wait--;
                    end
                end
            end
        end
    end

    // Launches one job and waits for finish; returns observations only.
    task automatic run_job(input logic [31:0] len, input logic [31:0] cst,
                           input logic [63:0] ib, input logic [63:0] ob,
                           input bit scramble, input bit keep_launch,
                           output bit got_fin, output int cycles,
                           output logic [31:0] ev_val, output bit ev_vld,
                           output bit fin_after);
        wr_log.delete();
        n_rd_req = 0;
        n_wr_req = 0;
        @(negedge clock);
        constant  = cst;
        length    = len;
        inp_baddr = ib;
        out_baddr = ob;
        launch    = 1'b1;
        got_fin   = 0;
        cycles    = 0;
        ev_val    = '0;
        ev_vld    = 0;
        fin_after = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clock);
            #1;
            cycles++;
            if (scramble) begin
                constant  = $urandom;
                length    = $urandom;
                inp_baddr = {$urandom, $urandom};
                out_baddr = {$urandom, $urandom};
                launch    = 1'($urandom_range(1));
            end
            if (finish) begin
                got_fin = 1;
                ev_val  = ev_value;
                ev_vld  = ev_valid;
                break;
            end
        end
        if (scramble) launch = 1'b1;
        @(posedge clock);
        #1;
        fin_after = finish;
        if (!keep_launch) begin
            launch = 1'b0;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        outs = {finish, ev_valid, ev_value, mem_if.mem_req_valid, mem_if.mem_req_opcode,
                mem_if.mem_req_addr, mem_if.mem_wr_valid, mem_if.mem_wr_bits, mem_if.mem_rd_ready};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({finish, mem_if.mem_req_valid, mem_if.mem_wr_valid, mem_if.mem_rd_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: fin=%b req=%b wr=%b rd=%b required all 0",
                     finish, mem_if.mem_req_valid, mem_if.mem_wr_valid, mem_if.mem_rd_ready);
        end
    endtask

    task automatic test_basic();
        bit fin, vld, fin_after;
        int cyc;
        logic [31:0] val;
        max_delay = 0;
        for (int k = 0; k < 4; k++) mem_arr[64'h1000 + 64'(8*k)] = 64'(k);
        run_job(4, 5, 64'h1000, 64'h2000, 0, 0, fin, cyc, val, vld, fin_after);
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL basic_finish: no finish within budget");
        end
        n_checks++;
        if (wr_log.size() != 4) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d required 4", wr_log.size());
        end
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            n_checks++;
            if (wr_log[k].addr !== 64'h2000 + 64'(8*k) || wr_log[k].data !== 64'(k + 5)) begin
                n_fail++;
                $display("FAIL basic_write_%0d: got %h@%h required %h@%h", k, wr_log[k].data,
                         wr_log[k].addr, 64'(k + 5), 64'h2000 + 64'(8*k));
            end
        end
        n_checks++;
        if (val !== 32'd17 || !vld) begin
            n_fail++;
            $display("FAIL basic_counter: got %0d valid %b required 17 valid 1", val, vld);
        end
        n_checks++;
        if (fin_after !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_finish_width: finish still %b one cycle later, required 0", fin_after);
        end
        n_checks++;
        if (n_rd_req != 4) begin
            n_fail++;
            $display("FAIL basic_read_count: got %0d required 4", n_rd_req);
        end
    endtask

    task automatic test_zero_length();
        bit fin, vld, fin_after;
        int cyc;
        logic [31:0] val;
        run_job(0, 9, 64'h1000, 64'h2000, 0, 0, fin, cyc, val, vld, fin_after);
        n_checks++;
        if (!fin || cyc != 1) begin
            n_fail++;
            $display("FAIL zero_len_latency: finish %b after %0d cycles required 1 after 1", fin, cyc);
        end
        n_checks++;
        if (val !== 32'd1 || !vld) begin
            n_fail++;
            $display("FAIL zero_len_counter: got %0d valid %b required 1 valid 1", val, vld);
        end
        n_checks++;
        if (n_rd_req + n_wr_req != 0) begin
            n_fail++;
            $display("FAIL zero_len_no_mem: got %0d requests required 0", n_rd_req + n_wr_req);
        end
    endtask

    task automatic test_stall();
        logic [63:0] first_addr;
        int low = 0;
        bit accepted = 0;
        bit fin = 0;
        max_delay = 0;
        mem_arr[64'h3000] = 64'h1234;
        n_rd_req = 0;
        wr_log.delete();
        forced_stall = 10;
        @(negedge clock);
        constant  = 32'h10;
        length    = 1;
        inp_baddr = 64'h3000;
        out_baddr = 64'h4000;
        launch    = 1'b1;
        @(posedge clock);
        #1;
        first_addr = mem_if.mem_req_addr;
        n_checks++;
        if (first_addr !== 64'h3000 || !mem_if.mem_req_valid) begin
            n_fail++;
            $display("FAIL stall_first_req: got valid %b addr %h required 1 addr 3000",
                     mem_if.mem_req_valid, first_addr);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            #1;
            n_checks++;
            if (!mem_if.mem_req_valid || mem_if.mem_req_addr !== first_addr) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid %b addr %h required 1 addr %h", k,
                         mem_if.mem_req_valid, mem_if.mem_req_addr, first_addr);
                break;
            end
            if (mem_if.mem_req_ready) begin
                accepted = 1;
                break;
            end
            low++;
        end
        n_checks++;
        if (!accepted || low != 10 || n_rd_req != 1) begin
            n_fail++;
            $display("FAIL stall_accept: accepted %b after %0d low cycles, %0d reads; required 1, 10, 1",
                     accepted, low, n_rd_req);
        end
        for (int k = 0; k < 100 && !fin; k++) begin
            @(posedge clock);
            #1;
            fin = finish;
        end
        launch = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (!fin || wr_log.size() != 1 || wr_log[0].data !== 64'h1244) begin
            n_fail++;
            $display("FAIL stall_result: finish %b writes %0d required finish 1 with one write of 1244",
                     fin, wr_log.size());
        end
    endtask

    task automatic test_overflow();
        bit fin, vld, fin_after;
        int cyc;
        logic [31:0] val;
        mem_arr[64'h5000] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_job(1, 1, 64'h5000, 64'h6000, 0, 0, fin, cyc, val, vld, fin_after);
        n_checks++;
        if (!fin || wr_log.size() != 1 || wr_log[0].data !== 64'h0 || wr_log[0].addr !== 64'h6000) begin
            n_fail++;
            $display("FAIL overflow_wrap: finish %b writes %0d data %h required 1, 1, 0 at 6000",
                     fin, wr_log.size(), (wr_log.size() > 0) ? wr_log[0].data : 64'hx);
        end
    endtask

    task automatic test_launch_hold();
        bit fin, vld, fin_after;
        int cyc;
        logic [31:0] val;
        int seen = 0;
        for (int k = 0; k < 2; k++) mem_arr[64'h7000 + 64'(8*k)] = 64'(100 + k);
        run_job(2, 3, 64'h7000, 64'h8000, 0, 1, fin, cyc, val, vld, fin_after);
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL hold_first_run: no finish within budget");
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            if (finish || mem_if.mem_req_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL hold_no_retrigger: %0d active cycles while launch held, required 0", seen);
        end
        launch = 1'b0;
        repeat (2) @(posedge clock);
        run_job(2, 3, 64'h7000, 64'h8000, 0, 0, fin, cyc, val, vld, fin_after);
        n_checks++;
        if (!fin || n_wr_req != 2) begin
            n_fail++;
            $display("FAIL hold_second_run: finish %b with %0d writes, required 1 with 2", fin, n_wr_req);
        end
    endtask

    task automatic test_random();
        bit fin, vld, fin_after;
        int cyc;
        logic [31:0] val;
        max_delay = 3;
        for (int j = 0; j < 6; j++) begin
            logic [31:0] len, cst;
            logic [63:0] ib, ob;
            len = 32'($urandom_range(6, 1));
            cst = $urandom;
            ib  = {$urandom, $urandom};
            ob  = {$urandom, $urandom};
            for (int k = 0; k < int'(len); k++) mem_arr[ib + 64'(8*k)] = {$urandom, $urandom};
            run_job(len, cst, ib, ob, 1, 0, fin, cyc, val, vld, fin_after);
            n_checks++;
            if (!fin || wr_log.size() != int'(len) || n_rd_req != int'(len)) begin
                n_fail++;
                $display("FAIL rand_%0d_shape: finish %b writes %0d reads %0d required 1, %0d, %0d",
                         j, fin, wr_log.size(), n_rd_req, len, len);
            end
            for (int k = 0; k < wr_log.size() && k < int'(len); k++) begin
                logic [63:0] exp_a, exp_d;
                exp_a = ob + 64'(8*k);
                exp_d = mem_arr[ib + 64'(8*k)] + {32'h0, cst};
                n_checks++;
                if (wr_log[k].addr !== exp_a || wr_log[k].data !== exp_d) begin
                    n_fail++;
                    $display("FAIL rand_%0d_write_%0d: got %h@%h required %h@%h", j, k,
                             wr_log[k].data, wr_log[k].addr, exp_d, exp_a);
                end
            end
            n_checks++;
            if (val !== 32'(cyc) || !vld) begin
                n_fail++;
                $display("FAIL rand_%0d_counter: got %0d valid %b required %0d valid 1", j, val, vld, cyc);
            end
        end
        max_delay = 0;
    endtask

    task automatic test_reset_midop();
        bit hit = 0;
        int active = 0;
        logic [255:0] outs;
        bit fin, vld, fin_after;
        int cyc;
        logic [31:0] val;
        max_delay    = 0;
        block_wr_req = 1;
        wr_log.delete();
        @(negedge clock);
        constant  = 7;
        length    = 2;
        inp_baddr = 64'h1000;
        out_baddr = 64'h9000;
        launch    = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            #1;
            if (mem_if.mem_req_valid && mem_if.mem_req_opcode) begin
                hit = 1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL midreset_reach_wr_req: write request never seen");
        end
        reset = 1'b0;
        #1;
        outs = {finish, ev_valid, ev_value, mem_if.mem_req_valid, mem_if.mem_req_opcode,
                mem_if.mem_req_addr, mem_if.mem_wr_valid, mem_if.mem_wr_bits, mem_if.mem_rd_ready};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h required 0", outs);
        end
        launch = 1'b0;
        block_wr_req = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            if (mem_if.mem_req_valid || finish || mem_if.mem_wr_valid) active++;
        end
        n_checks++;
        if (active != 0 || wr_log.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_abort: %0d active cycles %0d writes, required 0 and 0",
                     active, wr_log.size());
        end
        run_job(0, 0, 64'h0, 64'h0, 0, 0, fin, cyc, val, vld, fin_after);
        n_checks++;
        if (!fin || cyc != 1) begin
            n_fail++;
            $display("FAIL midreset_idle: finish %b after %0d cycles required 1 after 1", fin, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_stall();
        test_overflow();
        test_launch_hold();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vadd_sequencer.md
VADD_SEQUENCER -- requirements
Module: vadd_sequencer

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 64, memory byte-address width.
REQ-002 SHALL have parameter MEM_DATA_BITS, default 64, element and memory data width.
REQ-003 SHALL have parameter HOST_DATA_BITS, default 32, width of config and counter values.
REQ-004 SHALL have ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- launch  in  1  level; start request from the register file.
- finish  out  1  one-cycle completion pulse.
- event_counter_valid  out  1  cycle-count write strobe.
- event_counter_value  out  HOST_DATA_BITS  busy-cycle count.
- constant  in  HOST_DATA_BITS  addend.
- length  in  HOST_DATA_BITS  element count.
- inp_baddr, out_baddr  in  MEM_ADDR_BITS  input and output base byte addresses.
- mem_req_valid/mem_req_ready  out/in  1  request handshake.
- mem_req_opcode  out  1  0 = read, 1 = write.
- mem_req_addr  out  MEM_ADDR_BITS  element byte address.
- mem_wr_valid/mem_wr_ready  out/in  1  write-data handshake.
- mem_wr_bits  out  MEM_DATA_BITS  write data.
- mem_rd_valid/mem_rd_ready  in/out  1  read-data handshake.
- mem_rd_bits  in  MEM_DATA_BITS  read data.

Function
REQ-005 SHALL implement FSM states IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE and WAIT_CLR.
REQ-006 In IDLE with launch=1, SHALL snapshot constant, length, inp_baddr and out_baddr, clear index i and the cycle counter, then go to RD_REQ, or to DONE if length==0.
REQ-007 RD_REQ SHALL drive mem_req_valid=1, opcode=0 and addr=inp_baddr+8*i (modulo 2^MEM_ADDR_BITS), and SHALL advance to RD_DATA on the cycle valid&ready.
REQ-008 RD_DATA SHALL drive mem_rd_ready=1 and, on mem_rd_valid, SHALL register result = mem_rd_bits + zero-extended constant (modulo 2^MEM_DATA_BITS), then go to WR_REQ.
REQ-009 WR_REQ SHALL drive mem_req_valid=1, opcode=1 and addr=out_baddr+8*i, and SHALL advance on valid&ready.
REQ-010 WR_DATA SHALL drive mem_wr_valid=1 with mem_wr_bits=result; on mem_wr_ready it SHALL increment i and go to DONE if i+1==length, otherwise to RD_REQ.
REQ-011 Valid outputs SHALL hold stable, with unchanged address and data, until their handshake completes.
REQ-012 mem_req_valid, mem_wr_valid and mem_rd_ready SHALL be 0 in every state other than those listed above.
REQ-013 DONE SHALL last exactly one cycle, asserting finish=1 and event_counter_valid=1 with event_counter_value = count of cycles spent outside IDLE up to and including DONE; it then goes to WAIT_CLR.
REQ-014 WAIT_CLR SHALL return to IDLE only when launch==0, so a stale launch never retriggers.
REQ-015 launch changes and config-input changes while busy SHALL be ignored.
REQ-016 The cycle counter SHALL saturate at all-ones.
REQ-017 i SHALL be HOST_DATA_BITS wide; length=2^32-1 SHALL complete without wrap.

Reset
REQ-018 On reset=0, asynchronously: state=IDLE, i=0, counter=0, result=0.
REQ-019 On reset=0, all outputs SHALL be 0: finish, event_counter_valid, event_counter_value, mem_req_valid, mem_req_opcode, mem_req_addr, mem_wr_valid, mem_wr_bits and mem_rd_ready.
REQ-020 Reset mid-operation SHALL abort the transfer with no further memory requests; an in-flight memory response is the memory model's responsibility.

Structure
REQ-021 The state enum and the 8-byte stride constant SHALL reside in shared package vadd_pkg.
REQ-022 The saturating cycle counter SHALL be sub-module vadd_cycle_counter with inputs clear and enable, and output count.

Verification
REQ-023 Bench SHALL cover: length=4, constant=5, inp_baddr=0x1000, out_baddr=0x2000, input {0,1,2,3} -> writes {5,6,7,8} at 0x2000/08/10/18, then a finish pulse.
REQ-024 Bench SHALL cover: length=0 with launch -> finish on the 2nd cycle after launch, no memory request, event_counter_value=1.
REQ-025 Bench SHALL cover: mem_req_ready held low for 10 cycles -> address stable throughout and one request accepted.
REQ-026 Bench SHALL cover: mem_rd_bits=0xFFFF_FFFF_FFFF_FFFF and constant=1 -> write data 0.
REQ-027 Bench SHALL cover: launch held high for 5 cycles after finish -> no second run; after launch drops and rises again -> second run.
REQ-028 Bench SHALL cover: reset asserted during WR_REQ -> all outputs 0 immediately and IDLE afterwards.
